present_dec80: RTL and testbench

Iterative PRESENT-80 decryption core: takes a 64-bit ciphertext and the original 80-bit user key and returns the 64-bit plaintext. It first runs the forward key schedule to reach the last round-key state, then runs 31 inverse rounds, one round per cycle. It is the receive-side counterpart of the PRESENT encryption datapath built around `present_sbox`.

---
 rtl/present_pkg.sv | 8 +
 rtl/present_inv_sbox.sv | 28 ++
 rtl/present_sbox.sv | 28 ++
 rtl/present_dec80.sv | 79 +++++++
 tb/tb_present_dec80.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT round count, FSM encoding and pLayer index
package present_pkg;
  localparam int PRESENT_ROUNDS = 31;
  typedef enum logic [1:0] {IDLE, KEYEXP, DEC, FIN} state_t;
  function automatic logic [5:0] p_idx(input int j);
    return (j == 63) ? 6'd63 : 6'((16 * j) % 63);
  endfunction
endpackage

// File: rtl/present_inv_sbox.sv
// present_inv_sbox: inverse PRESENT 4-bit S-box
module present_inv_sbox (
  input  logic [3:0] x,
  output logic [3:0] y
);
  // inverse substitution table lookup
  always_comb begin
    y = 4'h0;
    case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'he;
      4'h2: y = 4'hf;
      4'h3: y = 4'h8;
      4'h4: y = 4'hc;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hd;
      4'h8: y = 4'hb;
      4'h9: y = 4'h4;
      4'ha: y = 4'h6;
      4'hb: y = 4'h3;
      4'hc: y = 4'h0;
      4'hd: y = 4'h7;
      4'he: y = 4'h9;
      default: y = 4'ha;
    endcase
  end
endmodule

// File: rtl/present_sbox.sv
// present_sbox: forward PRESENT 4-bit S-box
module present_sbox (
  input  logic [3:0] x,
  output logic [3:0] y
);
  // substitution table lookup
  always_comb begin
    y = 4'h0;
    case (x)
      4'h0: y = 4'hc;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hb;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'ha;
      4'h7: y = 4'hd;
      4'h8: y = 4'h3;
      4'h9: y = 4'he;
      4'ha: y = 4'hf;
      4'hb: y = 4'h8;
      4'hc: y = 4'h4;
      4'hd: y = 4'h7;
      4'he: y = 4'h1;
      default: y = 4'h2;
    endcase
  end
endmodule

// File: rtl/present_dec80.sv
// present_dec80: iterative PRESENT-80 decryption, key expansion then one inverse round per cycle
module present_dec80 import present_pkg::*; #(
  parameter int ROUNDS = PRESENT_ROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] cipher_in,
  input  logic [79:0] key_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] plain_out
);
  localparam logic [4:0] LAST = 5'(ROUNDS);
  state_t state, state_nx;
  logic [4:0] rc;
  logic [63:0] data_reg, ark, perm, sub;
  logic [79:0] key_reg, key_rot, key_fwd, key_x, key_t, key_inv;
  logic [3:0] s_out, is_out;
  logic accept;
  assign accept = start && !done;
  assign ark = data_reg ^ key_reg[79:16];
  for (genvar j = 0; j < 64; j++) begin : g_invp
    assign perm[j] = ark[p_idx(j)];
  end
  for (genvar n = 0; n < 16; n++) begin : g_invs
    present_inv_sbox u_isb (.x(perm[4*n +: 4]), .y(sub[4*n +: 4]));
  end
  assign key_rot = {key_reg[18:0], key_reg[79:19]};
  present_sbox u_ks (.x(key_rot[79:76]), .y(s_out));
  assign key_fwd = {s_out, key_rot[75:20], key_rot[19:15] ^ rc, key_rot[14:0]};
  assign key_x = {key_reg[79:20], key_reg[19:15] ^ rc, key_reg[14:0]};
  present_inv_sbox u_kis (.x(key_x[79:76]), .y(is_out));
  assign key_t = {is_out, key_x[75:0]};
  assign key_inv = {key_t[60:0], key_t[79:61]};
  // next-state logic; the done cycle still refuses start so throughput is one block per 65 cycles
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = accept ? KEYEXP : IDLE;
      KEYEXP:  state_nx = (rc == LAST) ? DEC : KEYEXP;
      DEC:     state_nx = (rc == 5'd1) ? FIN : DEC;
      default: state_nx = IDLE;
    endcase
  end
  // state, round counter, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rc <= '0;
      data_reg <= '0;
      key_reg <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      plain_out <= '0;
    end else begin
      state <= state_nx;
      busy <= (state_nx == KEYEXP) || (state_nx == DEC);
      done <= state == FIN;
      case (state)
        IDLE: if (accept) begin
          data_reg <= cipher_in;
          key_reg <= key_in;
          rc <= 5'd1;
        end
        KEYEXP: begin
          key_reg <= key_fwd;
          rc <= (rc == LAST) ? rc : rc + 5'd1;
        end
        DEC: begin
          data_reg <= sub;
          key_reg <= key_inv;
          rc <= rc - 5'd1;
        end
        default: plain_out <= ark;
      endcase
    end
  end
endmodule

// File: tb/tb_present_dec80.sv
// tb_present_dec80: scoreboard bench for present_dec80 against a forward-encryption reference model
module tb_present_dec80;
  typedef struct {
    logic [63:0] p;
    int          c;
  } exp_t;
  logic clk = 0, rst = 1, start = 0;
  logic [63:0] cipher_in = '0;
  logic [79:0] key_in = '0;
  logic busy, done;
  logic [63:0] plain_out;
  logic [3:0] sx, sy, iy;
  int checks = 0, failures = 0, cyc = 0, busy_cnt = 0;
  logic prev_done = 0;
  exp_t q[$];
  exp_t e;
  logic [3:0] sbox_t [16] = '{4'hc, 4'h5, 4'h6, 4'hb, 4'h9, 4'h0, 4'ha, 4'hd,
                              4'h3, 4'he, 4'hf, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  present_dec80 dut (.clk(clk), .rst(rst), .start(start), .cipher_in(cipher_in),
                     .key_in(key_in), .busy(busy), .done(done), .plain_out(plain_out));
  present_sbox u_s (.x(sx), .y(sy));
  present_inv_sbox u_i (.x(sy), .y(iy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference: straightforward PRESENT-80 encryption
  function automatic logic [63:0] enc(input logic [63:0] pt, input logic [79:0] k);
    logic [63:0] s, t;
    logic [79:0] kr;
    s = pt;
    kr = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kr[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox_t[s[4*n +: 4]];
      t = '0;
      for (int j = 0; j < 64; j++) t[(j == 63) ? 63 : (16 * j) % 63] = s[j];
      s = t;
      kr = {kr[18:0], kr[79:19]};
      kr[79:76] = sbox_t[kr[79:76]];
      kr[19:15] = kr[19:15] ^ 5'(r);
    end
    return s ^ kr[79:16];
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic issue(input logic [63:0] c, input logic [79:0] k, input logic [63:0] p);
    start = 1;
    cipher_in = c;
    key_in = k;
    q.push_back('{p, cyc});
    @(posedge clk); #1;
    start = 0;
    cipher_in = {$urandom, $urandom};
    key_in = {16'($urandom), $urandom, $urandom};
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: %0d jobs still pending after %0d cycles", q.size(), n);
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_job();
    logic [63:0] p;
    logic [79:0] k;
    p = {$urandom, $urandom};
    k = {16'($urandom), $urandom, $urandom};
    issue(enc(p, k), k, p);
    wait_done();
  endtask

  // monitor: pops the scoreboard on every done and checks value, latency and busy length
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      busy_cnt = busy_cnt + int'(busy);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 80'(plain_out), 80'(0) - 80'(1));
        end else begin
          e = q.pop_front();
          chk("plain_out", 80'(plain_out), 80'(e.p));
          chk("latency", 80'(cyc - e.c), 80'(64));
          chk("busy_cycles", 80'(busy_cnt), 80'(62));
        end
        busy_cnt = 0;
        if (prev_done) chk("done_width", 80'(1), 80'(0));
      end
    end
    prev_done = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int x = 0; x < 16; x++) begin
      sx = 4'(x);
      #1;
      chk("inv_sbox_roundtrip", 80'(iy), 80'(x));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 80'(busy), 80'(0));
    chk("reset_done", 80'(done), 80'(0));
    chk("reset_plain", 80'(plain_out), 80'(0));
    rst = 0;
    @(posedge clk); #1;
    issue(64'h5579C1387B228445, 80'h0, 64'h0);
    wait_done();
    issue(64'hE72C46C0F5945049, {80{1'b1}}, 64'h0);
    wait_done();
    issue(64'hA112FFC72F68417B, 80'h0, {64{1'b1}});
    wait_done();
    issue(64'h3333DCD3213210D2, {80{1'b1}}, {64{1'b1}});
    wait_done();
    repeat (6) rand_job();
    // start held high: only the first set and the set presented after the done cycle are taken
    begin
      logic [63:0] p;
      logic [79:0] k;
      p = {$urandom, $urandom};
      k = {16'($urandom), $urandom, $urandom};
      start = 1;
      cipher_in = enc(p, k);
      key_in = k;
      q.push_back('{p, cyc});
      for (int i = 0; i < 64; i++) begin
        @(posedge clk); #1;
        cipher_in = {$urandom, $urandom};
        key_in = {16'($urandom), $urandom, $urandom};
      end
      @(posedge clk); #1;
      p = {$urandom, $urandom};
      k = {16'($urandom), $urandom, $urandom};
      cipher_in = enc(p, k);
      key_in = k;
      q.push_back('{p, cyc});
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1;
        cipher_in = {$urandom, $urandom};
        key_in = {16'($urandom), $urandom, $urandom};
      end
      start = 0;
      wait_done();
    end
    // reset in the middle of a job discards it
    issue(64'h5579C1387B228445, 80'h0, 64'h0);
    repeat (39) @(posedge clk);
    #1;
    rst = 1;
    q.delete();
    @(posedge clk); #1;
    chk("midrst_busy", 80'(busy), 80'(0));
    chk("midrst_done", 80'(done), 80'(0));
    chk("midrst_plain", 80'(plain_out), 80'(0));
    rst = 0;
    repeat (80) @(posedge clk);
    #1;
    issue(64'h5579C1387B228445, 80'h0, 64'h0);
    wait_done();
    rand_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
